// File: rtl/calc_if.sv
// Keypad-to-display bus of the calculator core: key codes in, display value and status out.
interface calc_if #(
   parameter int unsigned DATA_W = 16
);
   logic [3:0]        key_code;
   logic              data_ready;
   logic [DATA_W-1:0] data_out;
   logic              err;
   logic [2:0]        state_out;

   modport master (
      output key_code,
      output data_ready,
      input  data_out,
      input  err,
      input  state_out
   );

   modport slave (
      input  key_code,
      input  data_ready,
      output data_out,
      output err,
      output state_out
   );
endinterface

// File: rtl/calc_core.sv
// Keypad calculator controller: multi-digit decimal entry, chained add/sub/mul,
// repeat-equals and latched overflow. Sits between the keypad scanner and the display.
module calc_core #(
   parameter int unsigned MAX_DIGITS = 4,
   parameter int unsigned DATA_W     = 16
) (
   input logic   clk,
   input logic   reset_in,
   calc_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic signed [DATA_W-1:0] TEN = DATA_W'(10);

   typedef enum logic [2:0] {
      StNumInit = 3'd0,
      StLhs     = 3'd1,
      StNumRhs  = 3'd2,
      StRhs     = 3'd3,
      StResult  = 3'd4,
      StError   = 3'd5
   } state_t;

   typedef enum logic [1:0] {OpAdd, OpSub, OpMul} op_t;

   state_t                   state, state_nx;
   op_t                      op, op_nx, key_op;
   logic signed [DATA_W-1:0] lhs, lhs_nx, rhs, rhs_nx;
   logic [CNT_W-1:0]         cnt, cnt_nx, cnt_app, cnt_bs, first_cnt;
   logic                     err, err_nx;
   logic [DATA_W-1:0]        data_out, data_out_nx;
   logic                     ready_prev, armed, key_event;
   logic                     is_digit, is_op, is_ce, is_eq, is_bs;
   logic [3:0]               digit;
   logic signed [DATA_W-1:0] dig_ext, operand, appended, trimmed, calc_res;
   logic signed [2*DATA_W-1:0] wide_lhs, wide_rhs, wide_res;
   logic                     full, ovf;

   // armed blocks a key held high across reset from firing until it has been released
   assign key_event = bus.data_ready && !ready_prev && armed;

   // Decode the {row, col} key code; every code maps to some key
   always_comb begin
      is_digit = 1'b0;
      is_op    = 1'b0;
      is_ce    = 1'b0;
      is_eq    = 1'b0;
      is_bs    = 1'b0;
      digit    = 4'd0;
      key_op   = OpAdd;
      if (bus.key_code[3:2] != 2'd3 && bus.key_code[1:0] != 2'd3) begin
         is_digit = 1'b1;
         digit    = {2'b00, bus.key_code[3:2]} * 4'd3 + {2'b00, bus.key_code[1:0]} + 4'd1;
      end else begin
         case (bus.key_code)
            4'b1101: is_digit = 1'b1;
            4'b1100: is_ce    = 1'b1;
            4'b1110: is_eq    = 1'b1;
            4'b0011: begin is_op = 1'b1; key_op = OpAdd; end
            4'b0111: begin is_op = 1'b1; key_op = OpSub; end
            4'b1011: begin is_op = 1'b1; key_op = OpMul; end
            default: is_bs    = 1'b1;
         endcase
      end
   end

   // Operand editing helpers and the wide arithmetic unit with overflow detection
   always_comb begin
      dig_ext   = DATA_W'(digit);
      operand   = (state == StRhs) ? rhs : lhs;
      full      = (cnt == CNT_W'(MAX_DIGITS));
      appended  = full ? operand : operand * TEN + dig_ext;
      cnt_app   = (full || (digit == 4'd0 && operand == '0)) ? cnt : cnt + CNT_W'(1);
      trimmed   = operand / TEN;
      cnt_bs    = (cnt == '0) ? cnt : cnt - CNT_W'(1);
      first_cnt = (digit == 4'd0) ? '0 : CNT_W'(1);
      wide_lhs  = {{DATA_W{lhs[DATA_W-1]}}, lhs};
      wide_rhs  = {{DATA_W{rhs[DATA_W-1]}}, rhs};
      case (op)
         OpSub:   wide_res = wide_lhs - wide_rhs;
         OpMul:   wide_res = wide_lhs * wide_rhs;
         default: wide_res = wide_lhs + wide_rhs;
      endcase
      // exact result fits only if the top DATA_W+1 bits are a pure sign extension
      ovf      = !(&wide_res[2*DATA_W-1:DATA_W-1]) && (|wide_res[2*DATA_W-1:DATA_W-1]);
      calc_res = wide_res[DATA_W-1:0];
   end

   // Next-state, register and display updates for one key event
   always_comb begin
      state_nx = state;
      op_nx    = op;
      lhs_nx   = lhs;
      rhs_nx   = rhs;
      cnt_nx   = cnt;
      err_nx   = err;
      if (key_event) begin
         if (is_ce) begin
            state_nx = StNumInit;
            op_nx    = OpAdd;
            lhs_nx   = '0;
            rhs_nx   = '0;
            cnt_nx   = '0;
            err_nx   = 1'b0;
         end else begin
            case (state)
               StNumInit, StResult: begin
                  if (is_digit) begin
                     lhs_nx   = dig_ext;
                     cnt_nx   = first_cnt;
                     state_nx = StLhs;
                  end else if (is_op) begin
                     op_nx    = key_op;
                     cnt_nx   = '0;
                     state_nx = StNumRhs;
                     if (state == StNumInit) lhs_nx = '0;
                  end else if (is_eq && state == StResult) begin
                     if (ovf) begin
                        err_nx   = 1'b1;
                        state_nx = StError;
                     end else begin
                        lhs_nx = calc_res;
                     end
                  end
               end
               StLhs: begin
                  if (is_digit) begin
                     lhs_nx = appended;
                     cnt_nx = cnt_app;
                  end else if (is_op) begin
                     op_nx    = key_op;
                     cnt_nx   = '0;
                     state_nx = StNumRhs;
                  end else if (is_eq) begin
                     state_nx = StResult;
                  end else if (is_bs) begin
                     lhs_nx = trimmed;
                     cnt_nx = cnt_bs;
                  end
               end
               StNumRhs: begin
                  if (is_digit) begin
                     rhs_nx   = dig_ext;
                     cnt_nx   = first_cnt;
                     state_nx = StRhs;
                  end else if (is_op) begin
                     op_nx = key_op;
                  end else if (is_eq) begin
                     state_nx = StResult;
                  end
               end
               StRhs: begin
                  if (is_digit) begin
                     rhs_nx = appended;
                     cnt_nx = cnt_app;
                  end else if (is_bs) begin
                     rhs_nx = trimmed;
                     cnt_nx = cnt_bs;
                  end else if (is_op || is_eq) begin
                     if (ovf) begin
                        err_nx   = 1'b1;
                        state_nx = StError;
                     end else begin
                        lhs_nx   = calc_res;
                        cnt_nx   = '0;
                        state_nx = is_op ? StNumRhs : StResult;
                        if (is_op) op_nx = key_op;
                     end
                  end
               end
               StError: ;
               default: state_nx = StNumInit;
            endcase
         end
      end
      case (state_nx)
         StLhs, StNumRhs, StResult: data_out_nx = lhs_nx;
         StRhs:                     data_out_nx = rhs_nx;
         default:                   data_out_nx = '0;
      endcase
   end

   // State and registered outputs; reset clears everything immediately
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state      <= StNumInit;
         op         <= OpAdd;
         lhs        <= '0;
         rhs        <= '0;
         cnt        <= '0;
         err        <= 1'b0;
         data_out   <= '0;
         ready_prev <= 1'b0;
         armed      <= 1'b0;
      end else begin
         state      <= state_nx;
         op         <= op_nx;
         lhs        <= lhs_nx;
         rhs        <= rhs_nx;
         cnt        <= cnt_nx;
         err        <= err_nx;
         data_out   <= data_out_nx;
         ready_prev <= bus.data_ready;
         armed      <= armed | ~bus.data_ready;
      end
   end

   assign bus.data_out  = data_out;
   assign bus.err       = err;
   assign bus.state_out = state;
endmodule

// File: doc/calc_core.md
# calc_core

Parametrised keypad calculator controller that replaces the fixed 3-bit entry FSM. It accepts debounced 4x4 keypad codes and accumulates multi-digit decimal operands. It applies add, subtract or multiply with operator chaining and repeat-equals, and flags overflow. It sits between the keypad scanner (`key_code`/`data_ready`) and the display driver (`data_out`).

## Interface
- `MAX_DIGITS`, default 4: maximum decimal digits per entered operand. Constraint: 10^MAX_DIGITS−1 ≤ 2^(DATA_W−1)−1.
- `DATA_W`, default 16: operand/result width, two's-complement signed.
- `clk` input, 1 bit: single clock, rising edge.
- `reset_in` input, 1 bit: asynchronous, active-high reset.
- `key_code` input, 4 bits: {row[1:0], col[1:0]} of the pressed key.
- `data_ready` input, 1 bit: high while `key_code` is valid.
- `data_out` output, DATA_W bits: operand being entered, or the last result.
- `err` output, 1 bit: overflow latched.
- `state_out` output, 3 bits: current state, for debug and display.

## Operation
- Key event: a cycle where `data_ready`=1 and the registered previous `data_ready`=0. A level held high counts once. Non-event cycles change nothing.
- Key decode:
  - digits: row<3 and col<3 give value 3·row+col+1; 4'b1101 gives 0.
  - 4'b1100 (*) is CE (clear all).
  - 4'b1110 (#) is EQUAL.
  - 4'b0011 is ADD, 4'b0111 is SUB, 4'b1011 is MUL.
  - 4'b1111 is BACKSPACE.
- Registers: `lhs`, `rhs`, `op` (reset ADD), `cnt` (digits entered).
- States: NUM_INIT=0, LHS=1, NUM_RHS=2, RHS=3, RESULT=4, ERROR=5.
- Digit entry: operand ← operand·10+d and cnt+1.
  - A digit is ignored when cnt=MAX_DIGITS.
  - A 0 while the operand is 0 leaves cnt unchanged (no leading zeros).
- BACKSPACE, in LHS/RHS only: operand ← operand/10 and cnt−1, floored at 0. It is ignored in all other states.
- CE in any state: all registers reset and the state goes to NUM_INIT. CE is the only exit from ERROR.
- Transitions (per event):
  - NUM_INIT:
    - digit: lhs=d, cnt=1 if d≠0 else 0 → LHS.
    - op: op stored, lhs=0 → NUM_RHS.
    - EQUAL: stay.
  - LHS:
    - digit: append.
    - op: store op → NUM_RHS.
    - EQUAL → RESULT (result = lhs).
  - NUM_RHS:
    - op: replace op.
    - digit: rhs=d → RHS.
    - EQUAL: result=lhs → RESULT.
  - RHS:
    - digit: append.
    - op: lhs ← lhs op rhs, store new op → NUM_RHS (chaining).
    - EQUAL: lhs ← lhs op rhs → RESULT.
  - RESULT:
    - digit: lhs=d, rhs kept → LHS.
    - op: store op → NUM_RHS.
    - EQUAL: lhs ← lhs op rhs (repeat last operation).
  - ERROR: only CE has an effect.
- Arithmetic:
  - Signed DATA_W, computed combinationally on the event.
  - MUL uses a 2·DATA_W-bit product.
  - Overflow occurs when the exact result falls outside [−2^(DATA_W−1), 2^(DATA_W−1)−1]. On overflow: err=1, data_out=0, state → ERROR.
- `data_out` by state:
  - LHS and RESULT show lhs.
  - RHS shows rhs.
  - NUM_RHS shows lhs, which is the chained result.
  - NUM_INIT and ERROR show 0.
- Unused codes: none exist, since all 16 codes are decoded.

## Timing
- Reset values: `data_out`=0, `err`=0, `state_out`=0. Internally lhs=rhs=0, op=ADD, cnt=0, previous data_ready=0.
- Latency: outputs reflect an event from the clock edge that detects it, i.e. they are visible the cycle after `data_ready` rises.
- Every event is single-cycle, so there is no back-pressure. Back-to-back events need `data_ready` to go low for at least one cycle between them.
- Asserting `reset_in` mid-entry or mid-cycle clears everything immediately, without waiting for a clock edge.
- If `data_ready` is high when reset deasserts, no event fires until it has been low for a cycle.
- `state_out` and `data_out` are registered, with no combinational path from inputs.

## Test plan
- Keys 1,2,ADD,3,EQUAL → data_out=15 (0x000F), state_out=4; a second EQUAL → 18; a third → 21.
- Keys 5,SUB,8,EQUAL → data_out=0xFFFD (−3), err=0. Then ADD,1,ADD → data_out=0xFFFE, state_out=2.
- Keys 1,2,3,4,5 → data_out=1234. BACKSPACE → 123. 0 in NUM_INIT followed by 0,7 → 7 with cnt=1.
- Keys 9,9,9,9,MUL,9,9,9,9,EQUAL → err=1, data_out=0, state_out=5. Digits and EQUAL are ignored. CE → err=0, state_out=0.
- `data_ready` held high 10 cycles with key 4 → data_out=4, not 4444. A glitch-free second pulse → 44.
- Async reset pulse mid-entry (after 1,2) between clock edges → all outputs 0 immediately. The next key 3 → data_out=3.
